// File: rtl/gpio_mmio_port_if.sv
// gpio_mmio_port_if
// Data-memory bus between the single-cycle RISC-V core (master) and the
// GPIO responder (slave).
//   sel       : chip select decoded from the core's address map
//   mem_write : store strobe, qualified by sel
//   mem_read  : load strobe, qualified by sel
//   addr      : byte offset into the GPIO window (addr[1:0] unused)
//   wdata     : store data
//   rdata     : load data, combinational from the slave
interface gpio_mmio_port_if;
    logic        sel;
    logic        mem_write;
    logic        mem_read;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel,
        output mem_write,
        output mem_read,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  mem_write,
        input  mem_read,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/gpio_mmio_port.sv
// gpio_mmio_port
// Memory-mapped GPIO responder for the core's data-memory bus.
//   clk           : single clock, rising edge
//   reset         : asynchronous active-high reset, clears all state
//   bus           : slave side of the data-memory bus (gpio_mmio_port_if)
//   gpio_port_in  : asynchronous external inputs, synchronized internally
//   gpio_port_out : registered outputs (DATA_OUT)
//   irq           : level interrupt, OR of all PENDING bits
// Register map: 0x00 DATA_IN (RO), 0x04 DATA_OUT (RW), 0x08 OUT_SET (WO),
// 0x0C OUT_CLR (WO), 0x10 EDGE_EN (RW), 0x14 PENDING (W1C), 0x18/0x1C
// read as zero and ignore writes.
module gpio_mmio_port #(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_mmio_port_if.slave      bus,
    input  logic [IN_WIDTH-1:0]  gpio_port_in,
    output logic [OUT_WIDTH-1:0] gpio_port_out,
    output logic                 irq
);

    // Word index of each register (addr[4:2])
    localparam logic [2:0] REG_DATA_IN  = 3'd0;
    localparam logic [2:0] REG_DATA_OUT = 3'd1;
    localparam logic [2:0] REG_OUT_SET  = 3'd2;
    localparam logic [2:0] REG_OUT_CLR  = 3'd3;
    localparam logic [2:0] REG_EDGE_EN  = 3'd4;
    localparam logic [2:0] REG_PENDING  = 3'd5;

    logic [IN_WIDTH-1:0]  syncChainQ [SYNC_STAGES];
    logic [IN_WIDTH-1:0]  syncPrevQ;
    logic [OUT_WIDTH-1:0] dataOutQ;
    logic [OUT_WIDTH-1:0] dataOutD;
    logic [IN_WIDTH-1:0]  edgeEnQ;
    logic [IN_WIDTH-1:0]  edgeEnD;
    logic [IN_WIDTH-1:0]  pendingQ;
    logic [IN_WIDTH-1:0]  pendingD;
    logic [IN_WIDTH-1:0]  syncVal;
    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  w1cMask;
    logic                 wrEn;
    logic                 rdEn;
    logic [2:0]           regSel;
    logic                 unusedAddr;

    assign wrEn       = bus.sel & bus.mem_write;
    assign rdEn       = bus.sel & bus.mem_read;
    assign regSel     = bus.addr[4:2];
    assign unusedAddr = ^bus.addr[1:0];

    assign syncVal = syncChainQ[SYNC_STAGES-1];
    assign rise    = syncVal & ~syncPrevQ & edgeEnQ;

    // Synchronizer chain plus one extra flop holding the previous
    // synchronized value for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncChainQ[i] <= '0;
            end
            syncPrevQ <= '0;
        end else begin
            syncChainQ[0] <= gpio_port_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncChainQ[i] <= syncChainQ[i-1];
            end
            syncPrevQ <= syncVal;
        end
    end

    // Store decode. Edge set is OR-ed in after the W1C mask so a rise
    // landing on the same edge as a clear keeps the bit set.
    always_comb begin
        dataOutD = dataOutQ;
        edgeEnD  = edgeEnQ;
        w1cMask  = '0;
        if (wrEn) begin
            case (regSel)
                REG_DATA_OUT: dataOutD = bus.wdata[OUT_WIDTH-1:0];
                REG_OUT_SET:  dataOutD = dataOutQ | bus.wdata[OUT_WIDTH-1:0];
                REG_OUT_CLR:  dataOutD = dataOutQ & ~bus.wdata[OUT_WIDTH-1:0];
                REG_EDGE_EN:  edgeEnD  = bus.wdata[IN_WIDTH-1:0];
                REG_PENDING:  w1cMask  = bus.wdata[IN_WIDTH-1:0];
                default:      ;
            endcase
        end
        pendingD = (pendingQ & ~w1cMask) | rise;
    end

    // Software-visible registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOutQ <= '0;
            edgeEnQ  <= '0;
            pendingQ <= '0;
        end else begin
            dataOutQ <= dataOutD;
            edgeEnQ  <= edgeEnD;
            pendingQ <= pendingD;
        end
    end

    // Zero-latency load path; reads see pre-write state when a load and
    // store coincide.
    always_comb begin
        bus.rdata = '0;
        if (rdEn) begin
            case (regSel)
                REG_DATA_IN:  bus.rdata = 32'(syncVal);
                REG_DATA_OUT: bus.rdata = 32'(dataOutQ);
                REG_EDGE_EN:  bus.rdata = 32'(edgeEnQ);
                REG_PENDING:  bus.rdata = 32'(pendingQ);
                default:      bus.rdata = '0;
            endcase
        end
    end

    assign gpio_port_out = dataOutQ;
    assign irq           = |pendingQ;

endmodule

// File: tb/tb_gpio_mmio_port.sv
// tb_gpio_mmio_port
// Directed testbench for gpio_mmio_port. Expected values are pushed to a
// scoreboard queue as each step is driven and popped when the DUT output
// for that step is sampled (one time unit after the rising edge, or one
// time unit after driving a combinational read).
module tb_gpio_mmio_port;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expT;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpioIn;
    logic [7:0]  gpioOut;
    logic        irq;
    logic [31:0] rd;

    expT expQ[$];
    int  vectors     = 0;
    int  miscompares = 0;

    gpio_mmio_port_if bus ();

    gpio_mmio_port #(
        .IN_WIDTH    (32),
        .OUT_WIDTH   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .gpio_port_in  (gpioIn),
        .gpio_port_out (gpioOut),
        .irq           (irq)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Drive one bus request
    task automatic applyStimulus(input logic s, input logic w, input logic r,
                                 input logic [4:0] a, input logic [31:0] d);
        bus.sel       = s;
        bus.mem_write = w;
        bus.mem_read  = r;
        bus.addr      = a;
        bus.wdata     = d;
    endtask

    task automatic busIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
    endtask

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, 1'b0, a, d);
        nextCycle();
        busIdle();
    endtask

    task automatic busRead(input logic [4:0] a, output logic [31:0] d);
        applyStimulus(1'b1, 1'b0, 1'b1, a, 32'h0);
        #1;
        d = bus.rdata;
        busIdle();
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] value);
        expT e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the observed value
    task automatic checkOutput(input logic [31:0] observed);
        expT e;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty observed=0x%08h expected=none", observed);
        end else begin
            e = expQ.pop_front();
            assert (observed === e.value) else begin
                miscompares++;
                $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", e.tag, observed, e.value);
            end
        end
    endtask

    initial begin
        busIdle();
        reset  = 1'b1;
        gpioIn = 32'hFFFF_FFFF;

        // Reset state with all inputs high
        repeat (3) @(posedge clk);
        #1;
        pushExpect("reset_gpio_out", 32'h0);       checkOutput(32'(gpioOut));
        pushExpect("reset_irq", 32'h0);            checkOutput(32'(irq));
        busRead(5'h14, rd);
        pushExpect("reset_pending_read", 32'h0);   checkOutput(rd);
        busRead(5'h00, rd);
        pushExpect("reset_data_in_read", 32'h0);   checkOutput(rd);

        // Release and watch the synchronizer fill
        reset = 1'b0;
        nextCycle();
        busRead(5'h00, rd);
        pushExpect("data_in_edge1", 32'h0);        checkOutput(rd);
        nextCycle();
        busRead(5'h00, rd);
        pushExpect("data_in_edge2", 32'hFFFF_FFFF); checkOutput(rd);
        repeat (3) nextCycle();
        pushExpect("irq_edge_en_off", 32'h0);      checkOutput(32'(irq));
        busRead(5'h14, rd);
        pushExpect("pending_edge_en_off", 32'h0);  checkOutput(rd);

        gpioIn = 32'h0;
        repeat (3) nextCycle();

        // Output register, set and clear
        busWrite(5'h04, 32'h0000_005A);
        pushExpect("out_write_5a", 32'h5A);        checkOutput(32'(gpioOut));
        busWrite(5'h08, 32'h0000_0081);
        pushExpect("out_set_db", 32'hDB);          checkOutput(32'(gpioOut));
        busWrite(5'h0C, 32'h0000_0018);
        pushExpect("out_clr_c3", 32'hC3);          checkOutput(32'(gpioOut));
        busRead(5'h04, rd);
        pushExpect("data_out_read", 32'h0000_00C3); checkOutput(rd);
        busRead(5'h08, rd);
        pushExpect("out_set_read", 32'h0);         checkOutput(rd);
        busRead(5'h0C, rd);
        pushExpect("out_clr_read", 32'h0);         checkOutput(rd);

        // Rising edge capture on bit 0
        busWrite(5'h10, 32'h0000_0001);
        busRead(5'h10, rd);
        pushExpect("edge_en_read", 32'h1);         checkOutput(rd);
        gpioIn = 32'h1;
        nextCycle();
        nextCycle();
        pushExpect("irq_after_2_edges", 32'h0);    checkOutput(32'(irq));
        nextCycle();
        pushExpect("irq_after_3_edges", 32'h1);    checkOutput(32'(irq));
        busRead(5'h14, rd);
        pushExpect("pending_after_rise", 32'h1);   checkOutput(rd);

        busWrite(5'h14, 32'h0000_0001);
        pushExpect("irq_after_w1c", 32'h0);        checkOutput(32'(irq));
        busRead(5'h14, rd);
        pushExpect("pending_after_w1c", 32'h0);    checkOutput(rd);

        // Falling edge on bit 0 and activity on disabled bit 1
        gpioIn = 32'h2;
        repeat (4) nextCycle();
        busRead(5'h14, rd);
        pushExpect("no_set_fall_bit1_rise", 32'h0); checkOutput(rd);
        gpioIn = 32'h0;
        repeat (4) nextCycle();
        busRead(5'h14, rd);
        pushExpect("no_set_bit1_fall", 32'h0);     checkOutput(rd);

        // W1C colliding with a new rise on the same bit
        gpioIn = 32'h1;
        repeat (3) nextCycle();
        busRead(5'h14, rd);
        pushExpect("pending_before_collision", 32'h1); checkOutput(rd);
        gpioIn = 32'h0;
        repeat (3) nextCycle();
        gpioIn = 32'h1;
        nextCycle();
        nextCycle();
        busWrite(5'h14, 32'h0000_0001);
        busRead(5'h14, rd);
        pushExpect("collision_set_wins", 32'h1);   checkOutput(rd);
        pushExpect("collision_irq", 32'h1);        checkOutput(32'(irq));
        busWrite(5'h14, 32'h0000_0001);
        pushExpect("irq_drop_next_cycle", 32'h0);  checkOutput(32'(irq));
        busRead(5'h14, rd);
        pushExpect("pending_cleared", 32'h0);      checkOutput(rd);

        // Simultaneous load and store returns the pre-write value
        applyStimulus(1'b1, 1'b1, 1'b1, 5'h04, 32'h0000_0077);
        #1;
        pushExpect("rw_pre_write_value", 32'h0000_00C3); checkOutput(bus.rdata);
        nextCycle();
        busIdle();
        pushExpect("rw_write_performed", 32'h77);  checkOutput(32'(gpioOut));

        // Qualification by sel and unused offsets
        applyStimulus(1'b0, 1'b1, 1'b0, 5'h04, 32'h0000_003C);
        nextCycle();
        busIdle();
        pushExpect("sel0_write_ignored", 32'h77);  checkOutput(32'(gpioOut));
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h04, 32'h0);
        #1;
        pushExpect("sel0_read_zero", 32'h0);       checkOutput(bus.rdata);
        busIdle();
        busWrite(5'h18, 32'hFFFF_FFFF);
        pushExpect("off18_write_out", 32'h77);     checkOutput(32'(gpioOut));
        busRead(5'h10, rd);
        pushExpect("off18_write_edge_en", 32'h1);  checkOutput(rd);
        busRead(5'h14, rd);
        pushExpect("off18_write_pending", 32'h0);  checkOutput(rd);
        busRead(5'h18, rd);
        pushExpect("off18_read", 32'h0);           checkOutput(rd);
        busRead(5'h1C, rd);
        pushExpect("off1c_read", 32'h0);           checkOutput(rd);

        // Asynchronous reset between clock edges
        busWrite(5'h04, 32'h0000_00FF);
        pushExpect("out_ff_before_reset", 32'hFF); checkOutput(32'(gpioOut));
        busWrite(5'h10, 32'h0000_0003);
        gpioIn = 32'h0;
        repeat (3) nextCycle();
        gpioIn = 32'h3;
        repeat (3) nextCycle();
        busRead(5'h14, rd);
        pushExpect("pending_3_before_reset", 32'h3); checkOutput(rd);
        #2;
        reset = 1'b1;
        #1;
        pushExpect("async_reset_out", 32'h0);      checkOutput(32'(gpioOut));
        pushExpect("async_reset_irq", 32'h0);      checkOutput(32'(irq));
        #1;
        reset = 1'b0;
        nextCycle();
        busRead(5'h10, rd);
        pushExpect("edge_en_after_reset", 32'h0);  checkOutput(rd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_mmio_port.md
# gpio_mmio_port

Memory-mapped GPIO responder on the RISC-V core's data-memory bus. It answers the core's load/store accesses to the GPIO window. It drives the 8-bit `gpio_port_out` pins from a software-written register. It samples the 32-bit `gpio_port_in` pins through a synchronizer and latches rising edges into a write-1-to-clear pending register that raises `irq`.

## Interface
- `IN_WIDTH`, 32: width of `gpio_port_in`, DATA_IN, EDGE_EN and PENDING.
- `OUT_WIDTH`, 8: width of `gpio_port_out` and DATA_OUT.
- `SYNC_STAGES`, 2: flip-flop stages on `gpio_port_in`; legal range 2–3.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `sel`, in, 1: chip select, decoded by the core from the address map.
- `mem_write`, in, 1: store strobe; qualified by `sel`.
- `mem_read`, in, 1: load strobe; qualified by `sel`.
- `addr`, in, 5: byte offset into the window; `addr[1:0]` ignored.
- `wdata`, in, 32: store data.
- `rdata`, out, 32: load data.
- `gpio_port_in`, in, `IN_WIDTH`: asynchronous external inputs.
- `gpio_port_out`, out, `OUT_WIDTH`: registered external outputs.
- `irq`, out, 1: level interrupt, equal to |PENDING.

## Operation
- Register map (offset, access):
  - 0x00 DATA_IN, RO: synchronized input value.
  - 0x04 DATA_OUT, RW: output register; reads return the value zero-extended.
  - 0x08 OUT_SET, WO: DATA_OUT |= `wdata[OUT_WIDTH-1:0]`.
  - 0x0C OUT_CLR, WO: DATA_OUT &= ~`wdata[OUT_WIDTH-1:0]`.
  - 0x10 EDGE_EN, RW: per-bit rising-edge capture enable.
  - 0x14 PENDING, R/W1C: writing 1 clears the bit; writing 0 leaves it unchanged.
- Offsets 0x18–0x1C:
  - Reads return 0.
  - Writes are ignored.
- Reads of OUT_SET and OUT_CLR return 0.
- Writes to DATA_IN are ignored.
- A write takes effect only when `sel && mem_write`.
- `rdata` is 0 whenever `!(sel && mem_read)`.
- If `mem_write` and `mem_read` are both high, the read returns the pre-write value and the write is performed.
- Input path:
  - `gpio_port_in` passes through a `SYNC_STAGES`-deep flop chain to produce `sync`.
  - A further flop holds `sync_d`, the previous `sync` value.
  - rise = `sync & ~sync_d & EDGE_EN`.
- PENDING update each cycle: PENDING_next = (PENDING & ~w1c_mask) | rise.
  - w1c_mask is `wdata` on a write to 0x14, otherwise 0.
  - If an edge arrives in the same cycle as a W1C of the same bit, set wins: the bit stays 1.
- Clearing an EDGE_EN bit does not clear its PENDING bit.
- `gpio_port_out` is DATA_OUT driven directly from flops, with no combinational path from the bus.

## Timing
- Reset values, all 0: DATA_OUT, EDGE_EN, PENDING, sync chain, `sync_d`, `gpio_port_out`, `irq`, `rdata`.
- Reset asserted mid-operation clears all state asynchronously.
- After reset, operation resumes on the first rising edge with `reset` low.
- Write latency: a store in cycle N updates the register at the rising edge ending cycle N.
  - `gpio_port_out`, EDGE_EN and PENDING show the new value in cycle N+1.
- Read latency: 0. `rdata` is combinational from the register state in the same cycle, as the single-cycle core requires.
- Input latency:
  - A level change on `gpio_port_in` that is stable before edge k appears in DATA_IN after edge k+SYNC_STAGES-1 (2 edges for the default).
  - The corresponding PENDING bit and `irq` assert one edge later (3 edges for the default).
- A pulse shorter than one clock period may be missed; minimum guaranteed-capture width is one clock period plus setup time.
- `irq` is combinational from PENDING flops. It deasserts in the cycle after the W1C that clears the last set bit, unless a new edge lands on that same edge.

## Test plan
- Reset: hold `reset`=1 with `gpio_port_in`=0xFFFF_FFFF. Required: `gpio_port_out`=0x00, `irq`=0, read of 0x14 returns 0. After release, DATA_IN reads 0xFFFF_FFFF by the second edge and `irq` stays 0, because EDGE_EN=0.
- Output registers: write 0x04←0x5A, then 0x08←0x81, then 0x0C←0x18. Required: `gpio_port_out` is 0x5A, then 0xDB, then 0xC3, each in the cycle after its store. Read 0x04 returns 0x0000_00C3. Reads of 0x08/0x0C return 0.
- Edge capture: EDGE_EN←0x0000_0001, then `gpio_port_in` 0→1. Required: PENDING=0x1 and `irq`=1 exactly 3 edges later. A falling edge or any change on bit 1 does not set PENDING.
- W1C collision: with PENDING=0x1, write 0x14←0x1 in the same cycle that a new rise on bit 0 is registered. Required: PENDING stays 0x1. A later W1C alone clears it and drops `irq` in the next cycle.
- Qualification: store to 0x04 with `sel`=0. Required: `gpio_port_out` unchanged. Load with `sel`=0 returns `rdata`=0. Access to offset 0x18 returns 0 and changes no state.
- Async reset mid-run: with `gpio_port_out`=0xFF and PENDING=0x3, pulse `reset` high between clock edges. Required: `gpio_port_out`=0x00 and `irq`=0 before the next rising edge.
